// File: rtl/conv2d_patch_mac.sv
// Patch MAC: stores a 27-element patch, dots it with 16 ROM weight columns,
// streams requantised Q1.7 results. Optional macro CONV_RELU_EN clamps negatives to 0.
module conv2d_patch_mac #(
   parameter int unsigned KTAPS  = 27,
   parameter int unsigned OUT_CH = 16,
   parameter int unsigned ACC_W  = 24,
   parameter int unsigned SHIFT  = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   output logic [15:0] w_row,
   output logic [15:0] w_col,
   input  logic [7:0]  w_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic [3:0]  out_ch,
   output logic        out_last
);

   localparam int unsigned K_W    = $clog2(KTAPS);
   localparam int unsigned CH_W   = $clog2(OUT_CH);
   localparam int unsigned PROD_W = 16;

   typedef enum logic [1:0] {LOAD, MAC, EMIT} state_t;

   state_t                    state, state_nxt;
   logic [K_W-1:0]            k;
   logic [CH_W-1:0]           ch;
   logic signed [ACC_W-1:0]   acc, sum, shifted;
   logic signed [PROD_W-1:0]  prod;
   logic signed [7:0]         patch [KTAPS];
   logic [7:0]                q_sat, q;
   logic                      accept, k_last, ch_last;

   assign in_ready = (state == LOAD) & ~rst;
   assign accept   = in_valid & in_ready;
   assign k_last   = (k == K_W'(KTAPS - 1));
   assign ch_last  = (ch == CH_W'(OUT_CH - 1));
   assign w_row    = 16'(k);
   assign w_col    = 16'(ch);

   // Datapath: one tap per cycle, accumulator cleared implicitly at k == 0.
   assign prod    = PROD_W'(patch[k]) * PROD_W'($signed(w_data));
   assign sum     = ((k == '0) ? '0 : acc) + ACC_W'(prod);
   assign shifted = sum >>> SHIFT;

   // Saturate when the bits above the 8-bit result are not a pure sign extension.
   always_comb begin
      q_sat = shifted[7:0];
      if (!((&shifted[ACC_W-1:7]) || !(|shifted[ACC_W-1:7])))
         q_sat = shifted[ACC_W-1] ? 8'h80 : 8'h7F;
`ifdef CONV_RELU_EN
      q = q_sat[7] ? 8'h00 : q_sat;
`else
      q = q_sat;
`endif
   end

   always_comb begin
      state_nxt = state;
      case (state)
         LOAD:    if (accept && k_last) state_nxt = MAC;
         MAC:     if (k_last) state_nxt = EMIT;
         EMIT:    if (out_ready) state_nxt = ch_last ? LOAD : MAC;
         default: state_nxt = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= LOAD;
         k         <= '0;
         ch        <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         out_last  <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            LOAD: begin
               if (accept) begin
                  k <= k_last ? '0 : k + 1'b1;
                  if (k_last) ch <= '0;
               end
            end
            MAC: begin
               acc <= sum;
               if (k_last) begin
                  out_data  <= q;
                  out_ch    <= 4'(ch);
                  out_last  <= ch_last;
                  out_valid <= 1'b1;
               end else begin
                  k <= k + 1'b1;
               end
            end
            EMIT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  k         <= '0;
                  if (!ch_last) ch <= ch + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Patch storage needs no reset; a new load overwrites every element.
   always_ff @(posedge clk) begin
      if (!rst && accept) patch[k] <= $signed(in_data);
   end

endmodule

// File: doc/conv2d_patch_mac.md
# conv2d_patch_mac

Consumer of the first-layer conv2d kernel ROM (27 taps × 16 output channels, Q1.7). Accepts one 3×3×3 input patch as a serial stream and stores it. For each output channel it drives the ROM address, multiplies each tap by the matching patch element, and accumulates 27 products. Each channel's sum is requantised to Q1.7 with saturation and streamed out over a valid/ready handshake. It sits between the patch/line-buffer stage and the activation/pooling stage.

## Interface
- `KTAPS`, 27: patch elements per window; equals the number of ROM rows.
- `OUT_CH`, 16: output channels; equals the number of ROM columns.
- `ACC_W`, 24: signed accumulator width.
- `SHIFT`, 7: right-shift applied when requantising from Q2.14 to Q1.7.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: patch element valid.
- `in_ready` out 1: block accepts a patch element.
- `in_data` in 8: signed Q1.7 patch element.
- `w_row` out 16: ROM row address (tap index k).
- `w_col` out 16: ROM column address (channel ch).
- `w_data` in 8: signed Q1.7 weight; combinational ROM read, valid the same cycle.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_data` out 8: signed Q1.7 channel result.
- `out_ch` out 4: channel index of `out_data`.
- `out_last` out 1: high with the channel `OUT_CH-1` result.

## Operation
- The FSM has three states: LOAD, MAC, EMIT. Counters are `k` (0..26) and `ch` (0..15).
- **LOAD**
  - `in_ready` = 1.
  - On each accepted beat (`in_valid & in_ready`), `patch[k] <= in_data` and `k` increments.
  - After the 27th beat is accepted: `k <= 0`, `ch <= 0`, go to MAC.
  - Patch element order equals ROM row order.
- **MAC**
  - `in_ready` = 0.
  - Each cycle: `acc <= (k==0 ? 0 : acc) + patch[k]*w_data`.
  - The product is full 16-bit signed, sign-extended to `ACC_W`. The worst case of ±442368 fits, so no accumulator overflow is possible.
  - At k=26 the final sum is requantised: `q = (sum) >>> SHIFT` (arithmetic shift, floor), clamped to [-128,127].
  - On that same edge: `out_data <= q`, `out_ch <= ch`, `out_last <= (ch==15)`, `out_valid <= 1`, go to EMIT.
- **EMIT**
  - `out_valid`, `out_data`, `out_ch`, `out_last` are held stable until `out_ready`.
  - On handshake: `out_valid <= 0`.
    - If ch==15, go to LOAD with `k <= 0`.
    - Otherwise `ch <= ch+1`, `k <= 0`, go to MAC.
- ROM addressing:
  - `w_row = k` and `w_col = ch`, zero-extended, combinational from the counters.
  - Frozen in EMIT.
- Input beats presented outside LOAD are not accepted and have no effect.
- `out_ready` while `out_valid`=0 has no effect.

## Timing
- Reset, effective at the next edge while `rst`=1:
  - State = LOAD; k = 0; ch = 0; acc = 0.
  - `out_valid` = 0, `out_data` = 0, `out_ch` = 0, `out_last` = 0.
  - `w_row` = 0, `w_col` = 0.
  - `in_ready` is forced to 0 while `rst` is high.
- Reset mid-operation discards the stored patch and any partial or pending result. No output beat is produced for that patch.
- `out_valid` rises on the 27th edge after the edge that accepted the 27th input beat.
- With `out_ready` held high:
  - Successive `out_valid` pulses are exactly 28 cycles apart, each 1 cycle wide.
  - `in_ready` reasserts on the cycle after the ch 15 handshake.
  - Total is 448 cycles per patch after load.
- Backpressure stretches EMIT indefinitely; no data is lost or advanced.

## Configuration
- `CONV_RELU_EN`
  - Defined: after saturation, negative `q` is replaced by 0, so `out_data` ∈ [0,127].
  - Undefined: the signed saturated value [-128,127] is output.
  - Latency is identical in both cases.

## Test plan
The bench uses a behavioural weight model on `w_row`/`w_col`.
- **All-zero patch**, weights all 64 → 16 beats, `out_data`=0, `out_ch` 0..15, `out_last` only on ch 15.
- **One-hot patch**, patch[5]=64, others 0, weights w[k][ch]=8·ch−64 → `out_data` = 4·ch−32 (ch0 −32, ch15 28). With `CONV_RELU_EN`: 0 for ch≤8, then 4·ch−32.
- **Saturation:**
  - Patch all 127, weights all 64 → every channel 127.
  - Patch all −128, weights all 64 → −128 (0 with `CONV_RELU_EN`).
- **Backpressure:** `out_ready` low for 10 cycles while ch 4 is valid.
  - `out_valid`, `out_data`, `out_ch`, `w_col` are stable throughout.
  - `in_ready`=0; the ch 5 result is correct and appears 28 cycles after release.
- **Reset mid-MAC** at ch 7:
  - Next cycle `out_valid`=0.
  - After `rst` drops, `in_ready`=1.
  - A fresh patch yields 16 beats starting at `out_ch`=0.
- **Throughput:** `out_ready` tied high, two back-to-back patches.
  - 28-cycle output spacing.
  - `in_ready` rises 1 cycle after the ch 15 handshake.
  - The second patch's results match the model.
